sodor_mem_port_arbiter: RTL and testbench

- Parametrised N-requester arbiter that shares one Sodor-style memory port (req/resp, fcn/typ) among several core-side masters, e.g. imem, dmem and debug.
- Generalises the single-core fixed imem/dmem split to a configurable number of channels, with fixed or round-robin priority.
- Tracks outstanding requests in an in-order ID queue so every memory response is routed back to the requester that issued it.
- Sits between one or more cores and a single-ported memory.

---
 rtl/sodor_mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_sodor_mem_port_arbiter.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sodor_mem_port_arbiter.sv
// Shares one Sodor-style memory port among NUM_PORTS requesters. Arbitration is fixed
// priority or round-robin, and an in-order ID queue routes each response back to its issuer.
module sodor_mem_port_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int RR_MODE         = 0,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        io_req_valid,
    output logic [NUM_PORTS-1:0]        io_req_ready,
    input  logic [NUM_PORTS*ADDR_W-1:0] io_req_addr,
    input  logic [NUM_PORTS*DATA_W-1:0] io_req_data,
    input  logic [NUM_PORTS-1:0]        io_req_fcn,
    input  logic [NUM_PORTS*3-1:0]      io_req_typ,
    output logic [NUM_PORTS-1:0]        io_resp_valid,
    output logic [DATA_W-1:0]           io_resp_data,
    output logic                        io_mem_req_valid,
    input  logic                        io_mem_req_ready,
    output logic [ADDR_W-1:0]           io_mem_req_bits_addr,
    output logic [DATA_W-1:0]           io_mem_req_bits_data,
    output logic                        io_mem_req_bits_fcn,
    output logic [2:0]                  io_mem_req_bits_typ,
    input  logic                        io_mem_resp_valid,
    input  logic [DATA_W-1:0]           io_mem_resp_bits_data,
    output logic [CNT_W-1:0]            io_outstanding,
    output logic                        io_err_spurious
);

    localparam int ID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  grant_lo;
    logic [ID_W-1:0]  grant_hi;
    logic             hi_found;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  id_q [MAX_OUTSTANDING];
    logic [ID_W-1:0]  head_id;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             accept;
    logic             pop;
    logic             spurious;
    logic             err_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Round-robin is a cyclic search from rr_ptr: the lowest valid port at or above the
    // pointer, otherwise the lowest valid port overall.
    always_comb begin
        grant_lo = '0;
        grant_hi = '0;
        hi_found = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (io_req_valid[i]) begin
                grant_lo = ID_W'(i);
            end
            if (io_req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
                grant_hi = ID_W'(i);
                hi_found = 1'b1;
            end
        end
        if ((RR_MODE != 0) && hi_found) begin
            grant = grant_hi;
        end else begin
            grant = grant_lo;
        end
    end

    assign full             = (count == CNT_W'(MAX_OUTSTANDING));
    assign io_mem_req_valid = (|io_req_valid) & ~full & ~reset;
    assign accept           = io_mem_req_valid & io_mem_req_ready;

    always_comb begin
        io_req_ready         = '0;
        io_mem_req_bits_addr = '0;
        io_mem_req_bits_data = '0;
        io_mem_req_bits_fcn  = 1'b0;
        io_mem_req_bits_typ  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == ID_W'(i)) begin
                io_req_ready[i]      = io_mem_req_ready & ~full & ~reset;
                io_mem_req_bits_addr = io_req_addr[i*ADDR_W +: ADDR_W];
                io_mem_req_bits_data = io_req_data[i*DATA_W +: DATA_W];
                io_mem_req_bits_fcn  = io_req_fcn[i];
                io_mem_req_bits_typ  = io_req_typ[i*3 +: 3];
            end
        end
    end

    assign head_id  = id_q[head];
    assign pop      = io_mem_resp_valid & (count != '0) & ~reset;
    assign spurious = io_mem_resp_valid & (count == '0);

    always_comb begin
        io_resp_valid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            io_resp_valid[i] = pop & (head_id == ID_W'(i));
        end
    end

    assign io_resp_data    = io_mem_resp_bits_data;
    assign io_outstanding  = count;
    assign io_err_spurious = err_q;

    // ID storage needs no reset: an entry is only read while the count covers it.
    always_ff @(posedge clock) begin
        if (accept) begin
            id_q[tail] <= grant;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count  <= '0;
            head   <= '0;
            tail   <= '0;
            rr_ptr <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (spurious) begin
                err_q <= 1'b1;
            end
            if ((RR_MODE != 0) && accept) begin
                rr_ptr <= (grant == ID_W'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sodor_mem_port_arbiter.sv
// Bench for sodor_mem_port_arbiter: a fixed-priority and a round-robin instance are fed the
// same stimulus, and every cycle is compared with a queue-based reference model.
module tb_sodor_mem_port_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;
    localparam int CW = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic             reset;
    logic [NP-1:0]    req_valid;
    logic [NP*AW-1:0] req_addr;
    logic [NP*DW-1:0] req_data;
    logic [NP-1:0]    req_fcn;
    logic [NP*3-1:0]  req_typ;
    logic             mem_req_ready;
    logic             mem_resp_valid;
    logic [DW-1:0]    mem_resp_data;

    logic [NP-1:0] req_ready   [2];
    logic [NP-1:0] resp_valid  [2];
    logic [DW-1:0] resp_data   [2];
    logic          mem_valid   [2];
    logic [AW-1:0] mem_addr    [2];
    logic [DW-1:0] mem_data    [2];
    logic          mem_fcn     [2];
    logic [2:0]    mem_typ     [2];
    logic [CW-1:0] outstanding [2];
    logic          err         [2];

    sodor_mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
                             .MAX_OUTSTANDING(MO), .RR_MODE(0)) dut_fixed (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid), .io_req_ready(req_ready[0]),
        .io_req_addr(req_addr), .io_req_data(req_data),
        .io_req_fcn(req_fcn), .io_req_typ(req_typ),
        .io_resp_valid(resp_valid[0]), .io_resp_data(resp_data[0]),
        .io_mem_req_valid(mem_valid[0]), .io_mem_req_ready(mem_req_ready),
        .io_mem_req_bits_addr(mem_addr[0]), .io_mem_req_bits_data(mem_data[0]),
        .io_mem_req_bits_fcn(mem_fcn[0]), .io_mem_req_bits_typ(mem_typ[0]),
        .io_mem_resp_valid(mem_resp_valid), .io_mem_resp_bits_data(mem_resp_data),
        .io_outstanding(outstanding[0]), .io_err_spurious(err[0])
    );

    sodor_mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW),
                             .MAX_OUTSTANDING(MO), .RR_MODE(1)) dut_rr (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid), .io_req_ready(req_ready[1]),
        .io_req_addr(req_addr), .io_req_data(req_data),
        .io_req_fcn(req_fcn), .io_req_typ(req_typ),
        .io_resp_valid(resp_valid[1]), .io_resp_data(resp_data[1]),
        .io_mem_req_valid(mem_valid[1]), .io_mem_req_ready(mem_req_ready),
        .io_mem_req_bits_addr(mem_addr[1]), .io_mem_req_bits_data(mem_data[1]),
        .io_mem_req_bits_fcn(mem_fcn[1]), .io_mem_req_bits_typ(mem_typ[1]),
        .io_mem_resp_valid(mem_resp_valid), .io_mem_resp_bits_data(mem_resp_data),
        .io_outstanding(outstanding[1]), .io_err_spurious(err[1])
    );

    // Reference model: in-flight port IDs held oldest first, plus the round-robin pointer.
    int  mq   [2][MO+1];
    int  mcnt [2];
    int  mrr  [2];
    bit  merr [2];

    logic [NP-1:0] cap_ready [2];
    logic [NP-1:0] cap_resp  [2];
    logic          cap_mv    [2];
    logic [AW-1:0] cap_addr  [2];
    logic [DW-1:0] cap_rdata [2];
    logic [CW-1:0] cap_out   [2];
    logic          cap_err   [2];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int model_grant(input int k, input logic [NP-1:0] v);
        int idx;
        for (int j = 0; j < NP; j++) begin
            idx = (k == 0) ? j : (mrr[k] + j) % NP;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic rand_fields();
        req_addr = {$urandom, $urandom, $urandom};
        req_data = {$urandom, $urandom, $urandom};
        req_fcn  = NP'($urandom);
        req_typ  = (NP*3)'($urandom);
    endtask

    // Drive one cycle, compare every output against the model at the falling edge, then
    // advance the model to match the next rising edge.
    task automatic run_cycle(input logic rst, input logic [NP-1:0] v, input logic mr,
                             input logic rv, input logic [DW-1:0] rd);
        int g;
        bit any, full, mv, acc, pop;
        logic [NP-1:0] er, eresp;
        logic [AW+DW+3:0] ebits, abits;
        reset          = rst;
        req_valid      = v;
        mem_req_ready  = mr;
        mem_resp_valid = rv;
        mem_resp_data  = rd;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            cap_ready[k] = req_ready[k];
            cap_resp[k]  = resp_valid[k];
            cap_mv[k]    = mem_valid[k];
            cap_addr[k]  = mem_addr[k];
            cap_rdata[k] = resp_data[k];
            cap_out[k]   = outstanding[k];
            cap_err[k]   = err[k];
            g    = model_grant(k, v);
            any  = (v != '0);
            full = (mcnt[k] == MO);
            mv   = any && !full && !rst;
            acc  = mv && mr;
            pop  = rv && !rst && (mcnt[k] > 0);
            er = '0;
            if (acc) er[g] = 1'b1;
            eresp = '0;
            if (pop) eresp[mq[k][0]] = 1'b1;

            n_checks++;
            if (cap_mv[k] !== mv) begin
                n_fail++;
                $display("FAIL mem_req_valid inst%0d: got %b expected %b", k, cap_mv[k], mv);
            end
            if (any) begin
                n_checks++;
                if (cap_ready[k] !== er) begin
                    n_fail++;
                    $display("FAIL req_ready inst%0d: got %b expected %b", k, cap_ready[k], er);
                end
            end
            if (mv) begin
                ebits = {req_addr[g*AW +: AW], req_data[g*DW +: DW], req_fcn[g], req_typ[g*3 +: 3]};
                abits = {mem_addr[k], mem_data[k], mem_fcn[k], mem_typ[k]};
                n_checks++;
                if (abits !== ebits) begin
                    n_fail++;
                    $display("FAIL mem_req_bits inst%0d: got %h expected %h", k, abits, ebits);
                end
            end
            n_checks++;
            if (cap_resp[k] !== eresp) begin
                n_fail++;
                $display("FAIL resp_valid inst%0d: got %b expected %b", k, cap_resp[k], eresp);
            end
            if (pop) begin
                n_checks++;
                if (cap_rdata[k] !== rd) begin
                    n_fail++;
                    $display("FAIL resp_data inst%0d: got %h expected %h", k, cap_rdata[k], rd);
                end
            end
            n_checks++;
            if (cap_out[k] !== CW'(mcnt[k])) begin
                n_fail++;
                $display("FAIL outstanding inst%0d: got %0d expected %0d", k, cap_out[k], mcnt[k]);
            end
            n_checks++;
            if (cap_err[k] !== merr[k]) begin
                n_fail++;
                $display("FAIL err_spurious inst%0d: got %b expected %b", k, cap_err[k], merr[k]);
            end

            if (rst) begin
                mcnt[k] = 0;
                merr[k] = 1'b0;
                mrr[k]  = 0;
            end else begin
                if (pop) begin
                    for (int i = 0; i < MO; i++) mq[k][i] = mq[k][i+1];
                    mcnt[k]--;
                end else if (rv) begin
                    merr[k] = 1'b1;
                end
                if (acc) begin
                    mq[k][mcnt[k]] = g;
                    mcnt[k]++;
                    if (k == 1) mrr[k] = (g + 1) % NP;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rand_fields();
        run_cycle(1'b1, 3'b111, 1'b1, 1'b0, '0);
        run_cycle(1'b1, 3'b111, 1'b1, 1'b1, 32'h5);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_ready[k] !== '0 || cap_mv[k] !== 1'b0 || cap_resp[k] !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d: got ready=%b mv=%b resp=%b expected all 0",
                         k, cap_ready[k], cap_mv[k], cap_resp[k]);
            end
        end
        run_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_out[k] !== '0 || cap_err[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got out=%0d err=%b expected 0/0",
                         k, cap_out[k], cap_err[k]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        rand_fields();
        req_addr[0 +: AW]  = 32'h100;
        req_addr[AW +: AW] = 32'h200;
        run_cycle(1'b0, 3'b011, 1'b1, 1'b0, '0);
        n_checks++;
        if (cap_ready[0] !== 3'b001 || cap_addr[0] !== 32'h100) begin
            n_fail++;
            $display("FAIL fixed_grant: got ready=%b addr=%h expected 001/00000100",
                     cap_ready[0], cap_addr[0]);
        end
        run_cycle(1'b0, '0, 1'b1, 1'b1, 32'hAAAA);
        n_checks++;
        if (cap_resp[0] !== 3'b001 || cap_rdata[0] !== 32'hAAAA) begin
            n_fail++;
            $display("FAIL fixed_resp: got resp=%b data=%h expected 001/0000aaaa",
                     cap_resp[0], cap_rdata[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [NP-1:0] exp_rdy;
        run_cycle(1'b1, '0, 1'b1, 1'b0, '0);
        rand_fields();
        for (int i = 0; i < NP; i++) req_addr[i*AW +: AW] = 32'h1000 + 32'(i * 16);
        for (int c = 0; c < 6; c++) begin
            run_cycle(1'b0, 3'b111, 1'b1, (c > 0), 32'hC0 + 32'(c));
            exp_rdy = '0;
            exp_rdy[c % 3] = 1'b1;
            n_checks++;
            if (cap_ready[1] !== exp_rdy || cap_addr[1] !== 32'h1000 + 32'((c % 3) * 16)) begin
                n_fail++;
                $display("FAIL rr_grant cycle%0d: got ready=%b addr=%h expected %b", c,
                         cap_ready[1], cap_addr[1], exp_rdy);
            end
        end
        run_cycle(1'b0, '0, 1'b1, 1'b1, 32'hC6);
        n_checks++;
        if (cap_resp[1] !== 3'b100) begin
            n_fail++;
            $display("FAIL rr_last_resp: got %b expected 100", cap_resp[1]);
        end
    endtask

    task automatic test_full();
        for (int c = 0; c < MO; c++) run_cycle(1'b0, 3'b001, 1'b1, 1'b0, '0);
        run_cycle(1'b0, 3'b001, 1'b1, 1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_mv[k] !== 1'b0 || cap_out[k] !== CW'(MO)) begin
                n_fail++;
                $display("FAIL full_block inst%0d: got mv=%b out=%0d expected 0/4",
                         k, cap_mv[k], cap_out[k]);
            end
        end
        run_cycle(1'b0, 3'b001, 1'b1, 1'b1, 32'h77);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_ready[k] !== '0 || cap_resp[k] !== 3'b001) begin
                n_fail++;
                $display("FAIL full_pop_same_cycle inst%0d: got ready=%b resp=%b expected 000/001",
                         k, cap_ready[k], cap_resp[k]);
            end
        end
        run_cycle(1'b0, 3'b001, 1'b1, 1'b0, '0);
        run_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_out[k] !== CW'(MO)) begin
                n_fail++;
                $display("FAIL full_refill inst%0d: got %0d expected 4", k, cap_out[k]);
            end
        end
        for (int c = 0; c < MO; c++) run_cycle(1'b0, '0, 1'b1, 1'b1, $urandom);
    endtask

    task automatic test_push_pop();
        run_cycle(1'b0, 3'b010, 1'b1, 1'b0, '0);
        run_cycle(1'b0, 3'b001, 1'b1, 1'b0, '0);
        run_cycle(1'b0, 3'b100, 1'b1, 1'b1, 32'h1234);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_resp[k] !== 3'b010 || cap_rdata[k] !== 32'h1234 || cap_ready[k] !== 3'b100) begin
                n_fail++;
                $display("FAIL push_pop inst%0d: got resp=%b data=%h ready=%b expected 010/1234/100",
                         k, cap_resp[k], cap_rdata[k], cap_ready[k]);
            end
        end
        run_cycle(1'b0, '0, 1'b1, 1'b1, 32'h1);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_out[k] !== 3'd2 || cap_resp[k] !== 3'b001) begin
                n_fail++;
                $display("FAIL push_pop_count inst%0d: got out=%0d resp=%b expected 2/001",
                         k, cap_out[k], cap_resp[k]);
            end
        end
        run_cycle(1'b0, '0, 1'b1, 1'b1, 32'h2);
    endtask

    task automatic test_spurious();
        run_cycle(1'b0, '0, 1'b1, 1'b1, 32'hDEAD);
        run_cycle(1'b0, 3'b001, 1'b1, 1'b0, '0);
        run_cycle(1'b0, '0, 1'b1, 1'b1, 32'h9);
        run_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_err[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL spurious_sticky inst%0d: got %b expected 1", k, cap_err[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_cycle(1'b1, '0, 1'b1, 1'b0, '0);
        run_cycle(1'b0, 3'b001, 1'b1, 1'b0, '0);
        run_cycle(1'b0, 3'b010, 1'b1, 1'b0, '0);
        run_cycle(1'b0, 3'b100, 1'b1, 1'b0, '0);
        run_cycle(1'b1, '0, 1'b1, 1'b0, '0);
        run_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_out[k] !== '0 || cap_err[k] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid inst%0d: got out=%0d err=%b expected 0/0",
                         k, cap_out[k], cap_err[k]);
            end
        end
        run_cycle(1'b0, '0, 1'b1, 1'b1, 32'h55);
        run_cycle(1'b0, '0, 1'b1, 1'b0, '0);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (cap_err[k] !== 1'b1) begin
                n_fail++;
                $display("FAIL stale_resp inst%0d: got %b expected 1", k, cap_err[k]);
            end
        end
    endtask

    task automatic test_random();
        logic rv;
        for (int c = 0; c < 400; c++) begin
            rand_fields();
            rv = (mcnt[0] > 0) ? 1'($urandom % 2) : ($urandom % 16 == 0);
            run_cycle(($urandom % 64 == 0), NP'($urandom_range(0, 7)), ($urandom % 4 != 0),
                      rv, $urandom);
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0;
            mrr[k]  = 0;
            merr[k] = 1'b0;
        end
        reset          = 1'b1;
        req_valid      = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        rand_fields();
        @(posedge clock);
        #1;
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_full();
        test_push_pop();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
